// File: rtl/gate_test_seq_if.sv
// Signal bundle between the gate test sequencer and its controller / gate under test.
// master = controller side (requests a sweep, models the gate), slave = sequencer.
interface gate_test_seq_if;
  logic       start;
  logic       abort;
  logic [1:0] op_sel;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] result;
  logic [2:0] err_cnt;

  modport master (
    output start, abort, op_sel, dut_y,
    input  dut_a, dut_b, busy, done, pass, result, err_cnt
  );

  modport slave (
    input  start, abort, op_sel, dut_y,
    output dut_a, dut_b, busy, done, pass, result, err_cnt
  );
endinterface

// File: rtl/gate_test_seq.sv
// Gate test sequencer: drives the four input vectors of a 2-input gate, waits SETTLE
// cycles per vector, samples the gate output and counts mismatches against the chosen op.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start; results of the last sweep held
// ST_SETTLE  | stimulus applied, counting SETTLE cycles before sampling
// ST_SAMPLE  | one cycle: capture dut_y, compare, advance vector
// ST_DONE    | one cycle: done/pass registered on the edge leaving it
module gate_test_seq #(
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  gate_test_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] op;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic [3:0] result;
  logic [2:0] err_cnt;
  logic       done;
  logic       pass;

  logic       accept;
  logic       abort_run;
  logic       settle_tc;
  logic       exp_y;

  assign settle_tc = (cnt == SETTLE_LAST);

  always_comb begin
    exp_y = 1'b0;
    case (op)
      2'b00:   exp_y = ~vec[0];
      2'b01:   exp_y = vec[0] & vec[1];
      2'b10:   exp_y = vec[0] | vec[1];
      default: exp_y = vec[0] ^ vec[1];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    abort_run = 1'b0;
    case (state)
      ST_IDLE: begin
        // abort has priority over a simultaneous start
        if (bus.start && !bus.abort) begin
          accept    = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          abort_run = 1'b1;
          state_nxt = ST_IDLE;
        end else if (settle_tc) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          abort_run = 1'b1;
          state_nxt = ST_IDLE;
        end else if (vec == 2'd3) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op      <= 2'b00;
      vec     <= 2'd0;
      cnt     <= 4'd0;
      result  <= 4'd0;
      err_cnt <= 3'd0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op      <= bus.op_sel;
        vec     <= 2'd0;
        cnt     <= 4'd0;
        result  <= 4'd0;
        err_cnt <= 3'd0;
        pass    <= 1'b0;
      end else if (abort_run) begin
        vec     <= 2'd0;
        cnt     <= 4'd0;
        result  <= 4'd0;
        err_cnt <= 3'd0;
        pass    <= 1'b0;
      end else begin
        case (state)
          ST_SETTLE: cnt <= cnt + 4'd1;
          ST_SAMPLE: begin
            result[vec] <= bus.dut_y;
            if ((bus.dut_y != exp_y) && (err_cnt != 3'd4)) err_cnt <= err_cnt + 3'd1;
            // vector 3 stays applied after the sweep until the next start
            if (vec != 2'd3) begin
              vec <= vec + 2'd1;
              cnt <= 4'd0;
            end
          end
          ST_DONE: begin
            done <= 1'b1;
            pass <= (err_cnt == 3'd0);
          end
          default: ;
        endcase
      end
    end
  end

  // Stimulus comes straight from the vector register, so it only moves on SETTLE entry.
  assign bus.dut_a   = vec[0];
  assign bus.dut_b   = vec[1];
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done;
  assign bus.pass    = pass;
  assign bus.result  = result;
  assign bus.err_cnt = err_cnt;

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: directed sweep table, randomized sweeps against a truth-table
// model, and hand-written abort / reset sequences.
module tb_gate_test_seq;
  localparam int SETTLE  = 2;
  localparam int VEC_CYC = SETTLE + 1;
  localparam int LAT     = 4 * VEC_CYC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] y_op = 2'b00;
  logic [3:0] flip = 4'b0000;
  int checks = 0;
  int failures = 0;

  gate_test_seq_if bus ();

  gate_test_seq #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic ideal(input logic [1:0] op, input logic [1:0] v);
    case (op)
      2'b00:   return ~v[0];
      2'b01:   return v[0] & v[1];
      2'b10:   return v[0] | v[1];
      default: return v[0] ^ v[1];
    endcase
  endfunction

  // External gate: an ideal gate of type y_op with per-vector output inversion faults.
  assign bus.dut_y = ideal(y_op, {bus.dut_b, bus.dut_a}) ^ flip[{bus.dut_b, bus.dut_a}];

  function automatic void model(input logic [1:0] op, input logic [1:0] drv, input logic [3:0] fl,
                                output logic [3:0] r, output logic [2:0] e, output logic p);
    r = 4'd0;
    e = 3'd0;
    for (int v = 0; v < 4; v++) begin
      r[v] = ideal(drv, 2'(v)) ^ fl[v];
      if (r[v] != ideal(op, 2'(v))) e = e + 3'd1;
    end
    p = (e == 3'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.busy, bus.done, bus.pass, bus.result, bus.err_cnt, bus.dut_a, bus.dut_b};
  endfunction

  task automatic run_sweep(input string name, input logic [1:0] op, input bit repulse,
                           input bit abort_done, input logic [3:0] er, input logic [2:0] ee,
                           input logic ep);
    int done_at, done_cnt, busy_cnt, vec_bad;
    done_at = -1; done_cnt = 0; busy_cnt = 0; vec_bad = 0;
    bus.op_sel = op;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_sel = ~op;
    for (int n = 0; n < 16; n++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n < 4 * VEC_CYC && {bus.dut_b, bus.dut_a} != 2'(n / VEC_CYC)) vec_bad++;
      bus.start = repulse && (n == 2 || n == 6);
      bus.abort = abort_done && (n == 12);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check({name, ".done_at"},  done_at, LAT);
    check({name, ".done_cnt"}, done_cnt, 1);
    check({name, ".busy_cnt"}, busy_cnt, LAT);
    check({name, ".vec_bad"},  vec_bad, 0);
    check({name, ".result"},   bus.result, er);
    check({name, ".err_cnt"},  bus.err_cnt, ee);
    check({name, ".pass"},     bus.pass, ep);
  endtask

  task automatic run_abort(input string name, input logic [1:0] op, input int abort_edge);
    int done_cnt;
    done_cnt = 0;
    bus.op_sel = op;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < abort_edge; n++) begin
      bus.abort = (n == abort_edge - 1);
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    bus.abort = 1'b0;
    check({name, ".outs_after_abort"}, outs(), 13'd0);
    for (int n = 0; n < LAT + 2; n++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    check({name, ".no_done"}, done_cnt, 0);
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [1:0] drv;
    logic [3:0] fl;
    bit         repulse;
    bit         abort_done;
    logic [3:0] er;
    logic [2:0] ee;
    logic       ep;
  } sweep_vec_t;

  sweep_vec_t tbl[7];

  initial begin
    logic [3:0] mr;
    logic [2:0] me;
    logic       mp;
    logic [1:0] rop;

    tbl[0] = '{"and_ideal",        2'b01, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b1000, 3'd0, 1'b1};
    tbl[1] = '{"inv_buffer",       2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 4'b1010, 3'd4, 1'b0};
    tbl[2] = '{"xor_repulse",      2'b11, 2'b11, 4'b0000, 1'b1, 1'b0, 4'b0110, 3'd0, 1'b1};
    tbl[3] = '{"or_abort_in_done", 2'b10, 2'b10, 4'b0000, 1'b0, 1'b1, 4'b1110, 3'd0, 1'b1};
    tbl[4] = '{"inv_ideal",        2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0101, 3'd0, 1'b1};
    tbl[5] = '{"and_one_fault",    2'b01, 2'b01, 4'b0100, 1'b0, 1'b0, 4'b1100, 3'd1, 1'b0};
    tbl[6] = '{"or_vs_xor_gate",   2'b10, 2'b11, 4'b0000, 1'b0, 1'b0, 4'b0110, 3'd1, 1'b0};

    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.op_sel = 2'b00;

    #2;
    check("reset_outs", outs(), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      y_op = tbl[i].drv;
      flip = tbl[i].fl;
      run_sweep(tbl[i].name, tbl[i].op, tbl[i].repulse, tbl[i].abort_done,
                tbl[i].er, tbl[i].ee, tbl[i].ep);
    end

    for (int i = 0; i < 10; i++) begin
      rop  = 2'($urandom_range(0, 3));
      y_op = ($urandom_range(0, 1) == 1) ? rop : 2'($urandom_range(0, 3));
      flip = 4'($urandom_range(0, 15));
      model(rop, y_op, flip, mr, me, mp);
      run_sweep($sformatf("rand%0d", i), rop, 1'b0, 1'b0, mr, me, mp);
    end

    y_op = 2'b10;
    flip = 4'b0000;
    run_abort("or_abort_e6", 2'b10, 6);
    flip = 4'b1111;
    run_abort("or_abort_errs_e10", 2'b10, 10);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    check("start_with_abort_ignored", bus.busy, 1'b0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);

    // mid-sweep asynchronous reset, with errors already counted
    flip = 4'b1111;
    bus.op_sel = 2'b10;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_err_cnt", bus.err_cnt, 3'd2);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", outs(), 13'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", outs(), 13'd0);
    flip = 4'b0000;
    run_sweep("or_after_reset", 2'b10, 1'b0, 1'b0, 4'b1110, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gate_test_seq.md
GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 Parameter SETTLE, default 2, meaning cycles dut_a/dut_b are held before dut_y is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to run one truth-table sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate a running sweep.
REQ-006 op_sel  input  2  gate under test: 00 INV (y=~a), 01 AND, 10 OR, 11 XOR; latched on start acceptance.
REQ-007 dut_y  input  1  output of the external gate under test.
REQ-008 dut_a  output  1  registered stimulus A to the gate under test.
REQ-009 dut_b  output  1  registered stimulus B to the gate under test.
REQ-010 busy  output  1  high from the first cycle after start acceptance until the DONE cycle inclusive.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 pass  output  1  high when all four sampled results matched expected; valid from done until next start acceptance.
REQ-013 result  output  4  captured dut_y per vector; bit i = sample for vector i.
REQ-014 err_cnt  output  3  number of mismatching vectors (0..4).

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE, encoded in registers.
REQ-016 IDLE: start=1 and abort=0 -> latch op_sel, vec<=0, clear result, err_cnt, pass, settle counter; go SETTLE.
REQ-017 Vector mapping: dut_a=vec[0], dut_b=vec[1]; order 0,1,2,3; for INV dut_b still follows vec[1] and is ignored in the expected value.
REQ-018 SETTLE: counter increments each cycle; after SETTLE cycles in this state go SAMPLE.
REQ-019 SAMPLE (one cycle): result[vec]<=dut_y; if dut_y differs from expected(op, vec) then err_cnt<=err_cnt+1; if vec==3 go DONE, else vec<=vec+1, clear counter, go SETTLE.
REQ-020 DONE (one cycle): done=1, pass=(err_cnt==0) registered, next state IDLE.
REQ-021 Latency: start sampled at edge k -> done high in the cycle following edge k+4*(SETTLE+1)+1; SETTLE=2 gives 13 edges.
REQ-022 start while not IDLE SHALL be ignored (no queueing, no restart).
REQ-023 abort=1 in SETTLE or SAMPLE -> IDLE at next edge; done not pulsed; pass=0; result and err_cnt cleared; dut_a/dut_b return to 0.
REQ-024 abort=1 in DONE SHALL be ignored (done still pulses); abort with start in IDLE: abort wins, start ignored.
REQ-025 err_cnt SHALL not wrap; maximum value is 4.
REQ-026 dut_a/dut_b SHALL change only on entry to SETTLE and SHALL be stable throughout SETTLE and SAMPLE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and dut_a=0, dut_b=0, busy=0, done=0, pass=0, result=0, err_cnt=0, latched op=00, counter=0, vec=0, independent of clk.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep with no done pulse; first start after release behaves as from power-up.

Verification (SETTLE=2)
REQ-029 op_sel=01, dut_y driven by ideal AND of dut_a/dut_b -> done 13 edges after start, result=4'b1000, err_cnt=0, pass=1.
REQ-030 op_sel=00, dut_y tied to dut_a (buffer, not inverter) -> result=4'b1010, err_cnt=4, pass=0.
REQ-031 op_sel=11, ideal XOR, start re-pulsed at edges 3 and 7 -> single sweep only, one done pulse, result=4'b0110, pass=1.
REQ-032 op_sel=10, ideal OR, abort at edge 6 -> no done, busy low next cycle, result=0, err_cnt=0, dut_a=dut_b=0.
REQ-033 rst_n pulsed low between clock edges mid-sweep -> outputs zero before next edge; subsequent OR sweep gives result=4'b1110, pass=1.
REQ-034 Checker across all runs: dut_a/dut_b constant for 3 cycles per vector, done exactly one cycle wide, busy high 13 cycles.
